// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle control FSM for the tiny RV32I core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the ALU
// op code and the operand selects, and it resolves branches from the ALU
// zero flag. A watchdog halts the core when a memory access does not finish.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   instr                 IR contents (valid from DECODE onward)
//   alu_zero              ALU zero flag
//   imem_ready/dmem_ready memory handshake completions
//   imem_req, ir_we       instruction fetch request / IR load
//   dmem_req, dmem_we     data access request / store
//   alu_op                ALU_CTRL_* code
//   alu_a_sel/alu_b_sel   operand selects (A: RS1/PC/ZERO, B: RS2/IMM)
//   imm_sel               immediate format (I/S/B/U/J)
//   target_we             latch ALUOut into the branch-target register
//   pc_we, pc_src         PC update and source (PC+4/target/ALUOut&~1)
//   reg_we, wb_sel        register write and source (ALUOut/load/PC+4)
//   illegal_instr         one-cycle pulse on an unsupported opcode
//   halted                core halted (left only by reset)
//   state                 debug view of the FSM state
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  alu_op,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic [2:0]  imm_sel,
  output logic        target_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        illegal_instr,
  output logic        halted,
  output logic [2:0]  state
);

  // ALU_CTRL_* codes
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_LUI   = 4'd10;
  localparam logic [3:0] ALU_AUIPC = 4'd11;

  localparam logic [1:0] A_RS1 = 2'd0;
  localparam logic [1:0] A_PC = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_ALU = 2'd2;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } stateT;

  stateT curState, nextState;
  logic [CW-1:0] waitCnt;
  logic waitExpired;

  logic [2:0] funct3;
  logic isLui, isAuipc, isJal, isJalr, isBranch, isLoad, isStore;
  logic isOpImm, isOp, isSys, isLegal;
  logic [3:0] brOp;
  logic brTaken;

  function automatic logic [3:0] aluFunc(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  assign funct3 = instr[14:12];
  assign state = curState;
  assign waitExpired = (waitCnt == CW'(TIMEOUT - 1));

  always_comb begin
    isLui    = (instr[6:0] == 7'b0110111);
    isAuipc  = (instr[6:0] == 7'b0010111);
    isJal    = (instr[6:0] == 7'b1101111);
    isJalr   = (instr[6:0] == 7'b1100111);
    isBranch = (instr[6:0] == 7'b1100011);
    isLoad   = (instr[6:0] == 7'b0000011);
    isStore  = (instr[6:0] == 7'b0100011);
    isOpImm  = (instr[6:0] == 7'b0010011);
    isOp     = (instr[6:0] == 7'b0110011);
    // Only ECALL and EBREAK are supported from the SYSTEM space.
    isSys    = (instr == 32'h0000_0073) || (instr == 32'h0010_0073);
    isLegal  = isLui | isAuipc | isJal | isJalr | isBranch | isLoad |
               isStore | isOpImm | isOp | isSys;
  end

  // Branch compare: SUB for (in)equality, SLT/SLTU for ordering; GE forms
  // are taken when the "less than" result is zero.
  always_comb begin
    brOp = ALU_SUB;
    brTaken = 1'b0;
    case (funct3)
      3'b000: brTaken = alu_zero;
      3'b001: brTaken = !alu_zero;
      3'b100: begin brOp = ALU_SLT;  brTaken = !alu_zero; end
      3'b101: begin brOp = ALU_SLT;  brTaken = alu_zero;  end
      3'b110: begin brOp = ALU_SLTU; brTaken = !alu_zero; end
      3'b111: begin brOp = ALU_SLTU; brTaken = alu_zero;  end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      curState <= FETCH;
    end else begin
      curState <= nextState;
    end
  end

  // Any state change clears the count, which covers entry to FETCH and MEM.
  always_ff @(posedge clk) begin
    if (reset) begin
      waitCnt <= '0;
    end else if (nextState != curState) begin
      waitCnt <= '0;
    end else if ((curState == FETCH && !imem_ready) ||
                 (curState == MEM && !dmem_ready)) begin
      waitCnt <= waitCnt + CW'(1);
    end
  end

  always_comb begin
    nextState = curState;
    case (curState)
      FETCH: begin
        if (imem_ready) nextState = DECODE;
        else if (waitExpired) nextState = HALT;
      end
      DECODE: begin
        if (!isLegal) nextState = FETCH;
        else if (isSys) nextState = HALT;
        else nextState = EXEC;
      end
      EXEC: begin
        if (isLoad || isStore) nextState = MEM;
        else if (isBranch || isJal || isJalr) nextState = FETCH;
        else nextState = WB;
      end
      MEM: begin
        if (dmem_ready) nextState = isLoad ? WB : FETCH;
        else if (waitExpired) nextState = HALT;
      end
      WB:      nextState = FETCH;
      HALT:    nextState = HALT;
      default: nextState = FETCH;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    ir_we = 1'b0;
    dmem_req = 1'b0;
    dmem_we = 1'b0;
    alu_op = ALU_ADD;
    alu_a_sel = A_RS1;
    alu_b_sel = 1'b0;
    imm_sel = IMM_I;
    target_we = 1'b0;
    pc_we = 1'b0;
    pc_src = PC_PLUS4;
    reg_we = 1'b0;
    wb_sel = WB_ALU;
    illegal_instr = 1'b0;
    halted = 1'b0;
    case (curState)
      FETCH: begin
        imem_req = 1'b1;
        ir_we = imem_ready;
      end
      DECODE: begin
        // PC + offset is precomputed into the target register here.
        alu_a_sel = A_PC;
        alu_b_sel = 1'b1;
        target_we = 1'b1;
        if (isBranch) imm_sel = IMM_B;
        else if (isJal) imm_sel = IMM_J;
        if (!isLegal) begin
          illegal_instr = 1'b1;
          pc_we = 1'b1;
        end
      end
      EXEC: begin
        if (isOp) begin
          alu_op = aluFunc(funct3, instr[30]);
        end else if (isOpImm) begin
          alu_op = aluFunc(funct3, instr[30] && (funct3 == 3'b101));
          alu_b_sel = 1'b1;
        end else if (isLoad || isStore) begin
          alu_b_sel = 1'b1;
          imm_sel = isStore ? IMM_S : IMM_I;
        end else if (isBranch) begin
          alu_op = brOp;
          pc_we = 1'b1;
          pc_src = brTaken ? PC_TARGET : PC_PLUS4;
        end else if (isJal) begin
          pc_we = 1'b1;
          pc_src = PC_TARGET;
          reg_we = 1'b1;
          wb_sel = WB_PC4;
        end else if (isJalr) begin
          alu_b_sel = 1'b1;
          pc_we = 1'b1;
          pc_src = PC_ALU;
          reg_we = 1'b1;
          wb_sel = WB_PC4;
        end else if (isLui) begin
          alu_op = ALU_LUI;
          alu_a_sel = A_ZERO;
          alu_b_sel = 1'b1;
          imm_sel = IMM_U;
        end else if (isAuipc) begin
          alu_op = ALU_AUIPC;
          alu_a_sel = A_PC;
          alu_b_sel = 1'b1;
          imm_sel = IMM_U;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we = isStore;
        if (dmem_ready && isStore) pc_we = 1'b1;
      end
      WB: begin
        reg_we = 1'b1;
        wb_sel = isLoad ? WB_MEM : WB_ALU;
        pc_we = 1'b1;
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected output
// traces built from the instruction-level rules, a small ALU model that
// answers the zero flag, a directed vector table, random instructions and
// hand-written watchdog/reset sequences.
module tb_multicycle_ctrl;
  localparam int unsigned TO = 16;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3,
                         A_SLTU = 4'd4, A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7,
                         A_OR = 4'd8, A_AND = 4'd9, A_LUI = 4'd10, A_AUIPC = 4'd11;

  logic clk = 1'b0;
  logic reset, aluZero, imemReady, dmemReady;
  logic [31:0] instr, opA, opB, aluRes;
  logic imemReq, irWe, dmemReq, dmemWe, bSel, targetWe, pcWe, regWe, illegal, halted;
  logic [3:0] aluOp;
  logic [1:0] aSel, pcSrc, wbSel;
  logic [2:0] immSel, st;

  int nTests = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .instr(instr), .alu_zero(aluZero),
    .imem_ready(imemReady), .dmem_ready(dmemReady),
    .imem_req(imemReq), .ir_we(irWe), .dmem_req(dmemReq), .dmem_we(dmemWe),
    .alu_op(aluOp), .alu_a_sel(aSel), .alu_b_sel(bSel), .imm_sel(immSel),
    .target_we(targetWe), .pc_we(pcWe), .pc_src(pcSrc), .reg_we(regWe),
    .wb_sel(wbSel), .illegal_instr(illegal), .halted(halted), .state(st)
  );

  // Environment ALU: answers the zero flag for whatever op the DUT requests.
  always_comb begin
    case (aluOp)
      A_SUB:   aluRes = opA - opB;
      A_SLT:   aluRes = {31'b0, $signed(opA) < $signed(opB)};
      A_SLTU:  aluRes = {31'b0, opA < opB};
      default: aluRes = opA + opB;
    endcase
    aluZero = (aluRes == 32'd0);
  end

  typedef struct packed {
    logic imemReq, irWe, dmemReq, dmemWe;
    logic [3:0] aluOp;
    logic [1:0] aSel;
    logic bSel;
    logic [2:0] immSel;
    logic targetWe, pcWe;
    logic [1:0] pcSrc;
    logic regWe;
    logic [1:0] wbSel;
    logic illegal, halted;
    logic [2:0] st;
  } obs_t;

  obs_t act;
  assign act = {imemReq, irWe, dmemReq, dmemWe, aluOp, aSel, bSel, immSel,
                targetWe, pcWe, pcSrc, regWe, wbSel, illegal, halted, st};

  typedef struct {
    logic iRdy;
    logic dRdy;
    obs_t exp;
  } cyc_t;
  cyc_t q[$];

  typedef struct {
    string name;
    logic [31:0] in, a, b;
    int unsigned idly, ddly, cycles;
    logic [3:0] execOp;
  } vec_t;
  vec_t vecs[$];

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic obs_t base(input int unsigned s);
    obs_t o = '0;
    o.st = 3'(s);
    return o;
  endfunction

  function automatic void push(input logic ir, input logic dr, input obs_t e);
    cyc_t c;
    c.iRdy = ir;
    c.dRdy = dr;
    c.exp = e;
    q.push_back(c);
  endfunction

  function automatic logic [3:0] aluFor(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0: return alt ? A_SUB : A_ADD;
      3'd1: return A_SLL;
      3'd2: return A_SLT;
      3'd3: return A_SLTU;
      3'd4: return A_XOR;
      3'd5: return alt ? A_SRA : A_SRL;
      3'd6: return A_OR;
      default: return A_AND;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected per-cycle outputs for one instruction, from its class.
  task automatic buildTrace(input logic [31:0] in, input logic [31:0] a, input logic [31:0] b,
                            input int unsigned idly, input int unsigned ddly, output bit halts);
    obs_t o;
    logic [6:0] opc;
    logic [2:0] f3;
    bit isR, isI, isLd, isSt, isBr, isJal, isJalr, isLui, isAui, isSys, legal, taken;
    opc = in[6:0];
    f3 = in[14:12];
    isR = (opc == 7'h33); isI = (opc == 7'h13); isLd = (opc == 7'h03);
    isSt = (opc == 7'h23); isBr = (opc == 7'h63); isJal = (opc == 7'h6F);
    isJalr = (opc == 7'h67); isLui = (opc == 7'h37); isAui = (opc == 7'h17);
    isSys = (in == 32'h0000_0073) || (in == 32'h0010_0073);
    legal = isR | isI | isLd | isSt | isBr | isJal | isJalr | isLui | isAui | isSys;
    halts = 0;
    taken = 0;
    q.delete();
    for (int unsigned k = 0; k <= idly; k++) begin
      o = base(0); o.imemReq = 1; o.irWe = (k == idly);
      push(k == idly, rnd(), o);
    end
    o = base(1); o.aSel = 2'd1; o.bSel = 1; o.targetWe = 1;
    o.immSel = isBr ? 3'd2 : (isJal ? 3'd4 : 3'd0);
    if (!legal) begin
      o.illegal = 1; o.pcWe = 1;
      push(rnd(), rnd(), o);
      return;
    end
    push(rnd(), rnd(), o);
    if (isSys) begin
      halts = 1;
      o = base(5); o.halted = 1;
      push(rnd(), rnd(), o);
      push(1, 1, o);
      return;
    end
    o = base(2);
    if (isR) o.aluOp = aluFor(f3, in[30]);
    else if (isI) begin o.aluOp = aluFor(f3, in[30] && f3 == 3'd5); o.bSel = 1; end
    else if (isLd || isSt) begin o.bSel = 1; o.immSel = isSt ? 3'd1 : 3'd0; end
    else if (isBr) begin
      case (f3)
        3'd0: taken = (a == b);
        3'd1: taken = (a != b);
        3'd4: taken = ($signed(a) < $signed(b));
        3'd5: taken = ($signed(a) >= $signed(b));
        3'd6: taken = (a < b);
        default: taken = (a >= b);
      endcase
      o.aluOp = (f3[2:1] == 2'b00) ? A_SUB : (f3[1] ? A_SLTU : A_SLT);
      o.pcWe = 1; o.pcSrc = taken ? 2'd1 : 2'd0;
    end else if (isJal) begin
      o.pcWe = 1; o.pcSrc = 2'd1; o.regWe = 1; o.wbSel = 2'd2;
    end else if (isJalr) begin
      o.bSel = 1; o.pcWe = 1; o.pcSrc = 2'd2; o.regWe = 1; o.wbSel = 2'd2;
    end else if (isLui) begin
      o.aluOp = A_LUI; o.aSel = 2'd2; o.bSel = 1; o.immSel = 3'd3;
    end else begin
      o.aluOp = A_AUIPC; o.aSel = 2'd1; o.bSel = 1; o.immSel = 3'd3;
    end
    push(rnd(), rnd(), o);
    if (isBr || isJal || isJalr) return;
    if (isLd || isSt) begin
      for (int unsigned k = 0; k <= ddly; k++) begin
        o = base(3); o.dmemReq = 1; o.dmemWe = isSt;
        o.pcWe = isSt && (k == ddly);
        push(rnd(), k == ddly, o);
      end
      if (isSt) return;
    end
    o = base(4); o.regWe = 1; o.wbSel = isLd ? 2'd1 : 2'd0; o.pcWe = 1;
    push(rnd(), rnd(), o);
  endtask

  // Apply the queued trace; entered and left at 1 time unit after a rising edge.
  task automatic runTrace(input logic [31:0] in, input logic [31:0] a, input logic [31:0] b,
                          input string tag, output int unsigned nonFetch, output logic [3:0] execOp);
    int unsigned n = 0;
    cyc_t c;
    nonFetch = 0;
    execOp = 4'hF;
    instr = in; opA = a; opB = b;
    while (q.size() > 0) begin
      c = q.pop_front();
      imemReady = c.iRdy;
      dmemReady = c.dRdy;
      #4;
      if (act.st != 3'd0) nonFetch++;
      if (act.st == 3'd2) execOp = act.aluOp;
      nTests++;
      if (act !== c.exp) begin
        nFail++;
        $display("FAIL %s cyc%0d: got %h expected %h", tag, n, act, c.exp);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic doReset(input int unsigned cycles);
    reset = 1;
    imemReady = rnd(); dmemReady = rnd();
    repeat (cycles) @(posedge clk);
    #1;
    reset = 0;
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    logic [2:0] bf [6];
    logic [6:0] bad [4];
    r = $urandom();
    bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    bad = '{7'h7F, 7'h0F, 7'h00, 7'h5B};
    case ($urandom_range(0, 10))
      0: return {1'b0, r[30], 5'b0, r[24:7], 7'b0110011};
      1: return {r[31:7], 7'b0010011};
      2: return {r[31:15], 3'b010, r[11:7], 7'b0000011};
      3: return {r[31:15], 3'b010, r[11:7], 7'b0100011};
      4: return {r[31:15], bf[r % 6], r[11:7], 7'b1100011};
      5: return {r[31:7], 7'b1101111};
      6: return {r[31:15], 3'b000, r[11:7], 7'b1100111};
      7: return {r[31:7], 7'b0110111};
      8: return {r[31:7], 7'b0010111};
      9: return {r[31:7], bad[r[1:0]]};
      default: return r[0] ? 32'h0010_0073 : 32'h0000_0073;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit halts;
    int unsigned nf, cnt;
    logic [3:0] eop;
    logic [31:0] ri, ra, rb;

    vecs.push_back(vec_t'{"sub",      32'h4020_8133, 32'd5, 32'd3, 0, 0, 4, A_SUB});
    vecs.push_back(vec_t'{"beqT",     32'h0020_8463, 32'd7, 32'd7, 0, 0, 3, A_SUB});
    vecs.push_back(vec_t'{"beqN",     32'h0020_8463, 32'd7, 32'd8, 0, 0, 3, A_SUB});
    vecs.push_back(vec_t'{"bgeT",     32'h0020_D463, 32'd9, 32'd2, 0, 0, 3, A_SLT});
    vecs.push_back(vec_t'{"lw3",      32'h0000_A183, 32'd0, 32'd0, 0, 3, 8, A_ADD});
    vecs.push_back(vec_t'{"lwI2D3",   32'h0000_A183, 32'd0, 32'd0, 2, 3, 10, A_ADD});
    vecs.push_back(vec_t'{"sw",       32'h0020_A023, 32'd0, 32'd0, 0, 0, 4, A_ADD});
    vecs.push_back(vec_t'{"jal",      32'h0080_00EF, 32'd0, 32'd0, 0, 0, 3, A_ADD});
    vecs.push_back(vec_t'{"jalr",     32'h0000_80E7, 32'd0, 32'd0, 0, 0, 3, A_ADD});
    vecs.push_back(vec_t'{"lui",      32'h1234_52B7, 32'd0, 32'd0, 0, 0, 4, A_LUI});
    vecs.push_back(vec_t'{"auipc",    32'h0000_1297, 32'd0, 32'd0, 0, 0, 4, A_AUIPC});
    vecs.push_back(vec_t'{"srai",     32'h4030_D093, 32'd0, 32'd0, 0, 0, 4, A_SRA});
    vecs.push_back(vec_t'{"addiBit30", 32'h4000_8093, 32'd0, 32'd0, 0, 0, 4, A_ADD});
    vecs.push_back(vec_t'{"illegal",  32'h0000_007F, 32'd0, 32'd0, 0, 0, 2, 4'hF});
    vecs.push_back(vec_t'{"fetchEdge", 32'h4020_8133, 32'd1, 32'd1, TO - 1, 0, TO + 3, A_SUB});
    vecs.push_back(vec_t'{"memEdge",  32'h0000_A183, 32'd0, 32'd0, 0, TO - 1, TO + 4, A_ADD});

    instr = 32'h4020_8133; opA = 0; opB = 0;
    reset = 1; imemReady = 1; dmemReady = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    chk("rst-state", 32'(st), 32'd0);
    chk("rst-imemReq", 32'(imemReq), 32'd1);
    chk("rst-irWe", 32'(irWe), 32'd1);
    chk("rst-regWe", 32'(regWe), 32'd0);
    chk("rst-pcWe", 32'(pcWe), 32'd0);
    chk("rst-halted", 32'(halted), 32'd0);

    foreach (vecs[i]) begin
      buildTrace(vecs[i].in, vecs[i].a, vecs[i].b, vecs[i].idly, vecs[i].ddly, halts);
      runTrace(vecs[i].in, vecs[i].a, vecs[i].b, vecs[i].name, nf, eop);
      chk({vecs[i].name, "-cycles"}, vecs[i].idly + 1 + nf, vecs[i].cycles);
      if (vecs[i].execOp != 4'hF) chk({vecs[i].name, "-execOp"}, 32'(eop), 32'(vecs[i].execOp));
    end

    // ECALL halts; only reset leaves HALT.
    buildTrace(32'h0000_0073, 0, 0, 0, 0, halts);
    runTrace(32'h0000_0073, 0, 0, "ecall", nf, eop);
    chk("ecall-halted", 32'(halted), 32'd1);
    doReset(1);
    chk("ecall-rst-state", 32'(st), 32'd0);

    for (int n = 0; n < 80; n++) begin
      ri = randInstr();
      ra = $urandom();
      rb = rnd() ? ra : $urandom();
      buildTrace(ri, ra, rb, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), halts);
      runTrace(ri, ra, rb, $sformatf("rnd%0d_%h", n, ri), nf, eop);
      if (halts) doReset($urandom_range(1, 2));
    end

    // Fetch watchdog: imem never ready.
    doReset(1);
    imemReady = 0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      #4;
      if (halted) break;
      if (imemReq) cnt++;
      @(posedge clk); #1;
    end
    chk("fetchTo-reqCycles", cnt, TO);
    chk("fetchTo-halted", 32'(halted), 32'd1);
    chk("fetchTo-state", 32'(st), 32'd5);
    @(posedge clk); #1;
    imemReady = 1; dmemReady = 1;
    repeat (2) @(posedge clk);
    #4;
    chk("halt-sticky", 32'({halted, imemReq, dmemReq, pcWe, regWe}), 32'b10000);
    @(posedge clk); #1;
    doReset(1);
    chk("haltRst-state", 32'(st), 32'd0);
    chk("haltRst-halted", 32'(halted), 32'd0);

    // Data watchdog: load whose dmem never completes.
    instr = 32'h0000_A183; imemReady = 1; dmemReady = 0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      #4;
      if (halted) break;
      if (dmemReq) cnt++;
      @(posedge clk); #1;
    end
    chk("memTo-reqCycles", cnt, TO);
    chk("memTo-halted", 32'(halted), 32'd1);

    // Reset in the middle of a data access abandons it.
    doReset(1);
    instr = 32'h0020_A023; imemReady = 1; dmemReady = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("midRst-inMem", 32'({dmemReq, dmemWe}), 32'b11);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("midRst-state", 32'(st), 32'd0);
    chk("midRst-strobes", 32'({imemReq, dmemReq, dmemWe, pcWe}), 32'b1000);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
